seq_divider: RTL and testbench
==============================

# seq_divider

Sequential unsigned integer divider that computes quotient and remainder by restoring shift-and-subtract, one quotient bit per clock. It is the inverse companion of the add/subtract datapath: the add/subtract cell produces a sum or difference, and this block reverses multiplication by repeated trial subtraction. It sits beside the ALU as a multi-cycle functional unit with a start/busy/done handshake.

## Interface

Parameters:
- N, default 4, operand width in bits (N ≥ 2).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request to begin a division; sampled on the rising edge.
- dividend  input  N  unsigned dividend; sampled when start is accepted.
- divisor  input  N  unsigned divisor; sampled when start is accepted.
- busy  output  1  high while an iteration is in progress.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- quotient  output  N  registered quotient.
- remainder  output  N  registered remainder.
- div_by_zero  output  1  registered flag; set when the accepted divisor was 0.

## Operation

- States: IDLE, RUN, DONE.
- Working registers:
  - R, N+1 bits: partial remainder.
  - Q, N bits: dividend shifting out and quotient shifting in.
  - D, N bits: latched divisor.
  - Iteration counter, ⌈log2(N+1)⌉ bits.
- Start acceptance: start=1 is accepted only in IDLE or DONE. On acceptance, R←0, Q←dividend, D←divisor, counter←0.
  - If divisor≠0, next state is RUN.
  - If divisor=0, next state is DONE.
- start=1 while in RUN is ignored. It has no effect on the working registers or outputs.
- Each RUN cycle (restoring step):
  - T = {R[N-1:0], Q[N-1]} − {1'b0, D}, computed as N+1 bits.
  - If T is non-negative (T[N]=0): R←T and Q←{Q[N-2:0],1}.
  - Otherwise: R←{R[N-1:0], Q[N-1]} and Q←{Q[N-2:0],0}.
  - Counter increments. After the Nth RUN cycle, next state is DONE.
- Completion on entry to DONE (normal divide): quotient←Q, remainder←R[N-1:0], div_by_zero←0.
- Completion on entry to DONE (divisor=0): quotient←all ones, remainder←dividend, div_by_zero←1.
- DONE lasts one cycle. The next state is IDLE, unless a start is accepted in that cycle.
- quotient, remainder and div_by_zero hold their values until the next completion. Accepting a new start does not change them.
- Invariant for every non-zero divisor: dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing

- Reset: rst=1 at a rising edge forces IDLE. It clears busy, done, quotient, remainder, div_by_zero, R, Q, D and the counter to 0.
  - Reset overrides start in the same cycle.
  - Reset during RUN aborts the operation; no done pulse is produced.
- Normal latency: start is accepted at edge E0. busy=1 for cycles E0..E0+N−1 (N cycles). done=1 for exactly the one cycle after edge E0+N, with results valid in that same cycle.
- Divisor-zero latency: start is accepted at edge E0. busy stays 0. done=1 in the cycle after E0.
- busy and done are never high together. Both are Moore outputs decoded from the state register.
- Back-to-back: start=1 during the DONE cycle is accepted. busy rises in the following cycle, with no IDLE gap.
- dividend and divisor are don't-care except at the accepting edge. Changing them during RUN has no effect.

## Test plan

- N=4, dividend=13, divisor=4, start pulsed one cycle:
  - busy high for exactly 4 cycles.
  - done pulses once, in the 5th cycle after the start edge.
  - quotient=3, remainder=1, div_by_zero=0.
- N=4 extremes:
  - 15/1 gives quotient=15, remainder=0.
  - 15/15 gives quotient=1, remainder=0.
  - 5/7 gives quotient=0, remainder=5.
  - 0/3 gives quotient=0, remainder=0.
- N=4, dividend=9, divisor=0:
  - busy stays 0.
  - done appears one cycle after the start edge.
  - quotient=15, remainder=9, div_by_zero=1.
- Start 13/4, then at the 2nd busy cycle drive start=1 with 7/2:
  - The second start is ignored; result is quotient=3, remainder=1.
  - Then hold start=1 with 7/2 through the done cycle: it is accepted, and the next done gives quotient=3, remainder=1 (7=3·2+1).
  - Between the two operations, the outputs keep the first result until the second done.
- Reset mid-run: assert rst in the 2nd busy cycle of 14/3.
  - Next cycle: IDLE, all outputs 0, and no done pulse follows.
  - A subsequent 14/3 gives quotient=4, remainder=2.
- Exhaustive at N=4: all 256 dividend/divisor pairs.
  - Each checks the invariant dividend = quotient·divisor + remainder with remainder < divisor (or the zero-divisor rule).
  - Each checks busy length = 4 cycles and exactly one done pulse per accepted start.

Source files
------------

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring unsigned divider, one quotient bit per clock
//
// Computes dividend / divisor with a start/busy/done handshake.
// A non-zero divide takes N RUN cycles followed by a single DONE cycle.
// A zero divisor skips RUN and completes in one cycle with a saturated quotient.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        request a division; accepted in IDLE or DONE only
//   dividend     N-bit unsigned dividend, sampled on acceptance
//   divisor      N-bit unsigned divisor, sampled on acceptance
//   busy         high while iterating (RUN)
//   done         one-cycle completion pulse (DONE); results valid from this cycle
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  registered flag, set when the accepted divisor was 0

module seq_divider #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [N:0]    r_q;        // partial remainder
   logic [N-1:0]  q_q;        // dividend shifting out, quotient shifting in
   logic [N-1:0]  d_q;        // latched divisor
   logic [CW-1:0] cnt;        // completed RUN steps

   logic          accept;
   logic          divisor_zero;
   logic          last_step;
   logic [N:0]    shifted;
   logic [N:0]    trial;
   logic          step_ok;
   logic [N:0]    r_next;
   logic [N-1:0]  q_next;

   // One restoring step: shift the next dividend bit into the remainder and
   // try to subtract the divisor; keep the difference only if it did not borrow.
   always_comb begin
      shifted = (r_q << 1) | {{N{1'b0}}, q_q[N-1]};
      trial   = shifted - {1'b0, d_q};
      step_ok = ~trial[N];
      r_next  = step_ok ? trial : shifted;
      q_next  = {q_q[N-2:0], step_ok};
   end

   assign accept       = start && (state != RUN);
   assign divisor_zero = (divisor == '0);
   assign last_step    = (cnt == CW'(N - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and Moore outputs
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = divisor_zero ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (accept) begin
               state_next = divisor_zero ? DONE : RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Working registers and result registers. Results only change on a
   // completion, so accepting a non-zero divide leaves the previous answer
   // visible until the new done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         r_q <= '0;
         q_q <= dividend;
         d_q <= divisor;
         cnt <= '0;
         if (divisor_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end
      end else if (state == RUN) begin
         r_q <= r_next;
         q_q <= q_next;
         cnt <= cnt + CW'(1);
         if (last_step) begin
            quotient    <= q_next;
            remainder   <= r_next[N-1:0];
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference

module tb_seq_divider;

   localparam int N = 4;

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   int checks   = 0;
   int failures = 0;

   seq_divider #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer division, saturated quotient on divide-by-zero.
   function automatic logic [N-1:0] ref_quot(input int a, input int b);
      if (b == 0) return '1;
      return N'(a / b);
   endfunction

   function automatic logic [N-1:0] ref_rem(input int a, input int b);
      if (b == 0) return N'(a);
      return N'(a % b);
   endfunction

   // Issues one start and observes up to N+4 cycles after the accepting edge.
   // Cycle c is the cycle following edge E0+c-1 (c=1 is right after acceptance).
   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output int busy_n, output int done_n, output int done_at,
                        output int overlap, output logic [N-1:0] q,
                        output logic [N-1:0] r, output logic z);
      busy_n  = 0;
      done_n  = 0;
      done_at = 0;
      overlap = 0;
      q       = '0;
      r       = '0;
      z       = 1'b0;
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      for (int c = 1; c <= N + 4; c++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (busy && done) overlap++;
         if (done) begin
            done_n++;
            if (done_at == 0) begin
               done_at = c;
               q       = quotient;
               r       = remainder;
               z       = div_by_zero;
            end
         end
         if (c == 1) begin
            start    = 1'b0;
            dividend = N'($urandom);
            divisor  = N'($urandom);
         end
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      start    = 1'b1;
      dividend = 4'd9;
      divisor  = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: busy=%b done=%b q=%0d r=%0d dbz=%b, required all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      int bn, dn, da, ov;
      logic [N-1:0] q, r;
      logic z;
      do_op(4'd13, 4'd4, bn, dn, da, ov, q, r, z);
      checks++;
      if (bn !== N) begin
         failures++;
         $display("FAIL basic_busy_len: got %0d, required %0d", bn, N);
      end
      checks++;
      if (dn !== 1 || da !== N + 1) begin
         failures++;
         $display("FAIL basic_done: count=%0d at=%0d, required count=1 at=%0d", dn, da, N + 1);
      end
      checks++;
      if (q !== 4'd3 || r !== 4'd1 || z !== 1'b0) begin
         failures++;
         $display("FAIL basic_result: q=%0d r=%0d dbz=%b, required q=3 r=1 dbz=0", q, r, z);
      end
      checks++;
      if (ov !== 0) begin
         failures++;
         $display("FAIL basic_overlap: busy&done seen %0d times, required 0", ov);
      end
   endtask

   task automatic test_extremes();
      int ta[4] = '{15, 15, 5, 0};
      int tb[4] = '{1, 15, 7, 3};
      int tq[4] = '{15, 1, 0, 0};
      int tr[4] = '{0, 0, 5, 0};
      int bn, dn, da, ov;
      logic [N-1:0] q, r;
      logic z;
      for (int i = 0; i < 4; i++) begin
         do_op(N'(ta[i]), N'(tb[i]), bn, dn, da, ov, q, r, z);
         checks++;
         if (q !== N'(tq[i]) || r !== N'(tr[i]) || z !== 1'b0 || dn !== 1) begin
            failures++;
            $display("FAIL extreme_%0d_%0d: q=%0d r=%0d dbz=%b dones=%0d, required q=%0d r=%0d dbz=0 dones=1",
                     ta[i], tb[i], q, r, z, dn, tq[i], tr[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      int bn, dn, da, ov;
      logic [N-1:0] q, r;
      logic z;
      do_op(4'd9, 4'd0, bn, dn, da, ov, q, r, z);
      checks++;
      if (bn !== 0) begin
         failures++;
         $display("FAIL dz_busy: busy cycles=%0d, required 0", bn);
      end
      checks++;
      if (dn !== 1 || da !== 1) begin
         failures++;
         $display("FAIL dz_done: count=%0d at=%0d, required count=1 at=1", dn, da);
      end
      checks++;
      if (q !== 4'd15 || r !== 4'd9 || z !== 1'b1) begin
         failures++;
         $display("FAIL dz_result: q=%0d r=%0d dbz=%b, required q=15 r=9 dbz=1", q, r, z);
      end
   endtask

   // 13/4 started; from cycle 2 start is held with 7/2 through the done cycle.
   // The RUN-time start is ignored, the DONE-time start is accepted back to back.
   task automatic test_back_to_back();
      logic exp_busy, exp_done;
      @(negedge clk);
      start    = 1'b1;
      dividend = 4'd13;
      divisor  = 4'd4;
      for (int c = 1; c <= 2 * N + 4; c++) begin
         @(negedge clk);
         exp_busy = (c >= 1 && c <= N) || (c >= N + 2 && c <= 2 * N + 1);
         exp_done = (c == N + 1) || (c == 2 * N + 2);
         checks++;
         if (busy !== exp_busy || done !== exp_done) begin
            failures++;
            $display("FAIL b2b_handshake_c%0d: busy=%b done=%b, required busy=%b done=%b",
                     c, busy, done, exp_busy, exp_done);
         end
         if (c >= N + 1) begin
            checks++;
            if (quotient !== 4'd3 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
               failures++;
               $display("FAIL b2b_result_c%0d: q=%0d r=%0d dbz=%b, required q=3 r=1 dbz=0",
                        c, quotient, remainder, div_by_zero);
            end
         end
         if (c == 1) begin
            dividend = 4'd7;
            divisor  = 4'd2;
         end
         if (c == N + 2) start = 1'b0;
      end
   endtask

   task automatic test_reset_mid_run();
      int bn, dn, da, ov;
      logic [N-1:0] q, r;
      logic z;
      int stray_done;
      @(negedge clk);
      start    = 1'b1;
      dividend = 4'd14;
      divisor  = 4'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
         failures++;
         $display("FAIL midrst_clear: busy=%b done=%b q=%0d r=%0d dbz=%b, required all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
      stray_done = 0;
      for (int c = 0; c < N + 4; c++) begin
         @(negedge clk);
         if (done || busy) stray_done++;
      end
      checks++;
      if (stray_done !== 0) begin
         failures++;
         $display("FAIL midrst_no_done: activity cycles=%0d, required 0", stray_done);
      end
      do_op(4'd14, 4'd3, bn, dn, da, ov, q, r, z);
      checks++;
      if (q !== 4'd4 || r !== 4'd2 || z !== 1'b0 || dn !== 1) begin
         failures++;
         $display("FAIL midrst_rerun: q=%0d r=%0d dbz=%b dones=%0d, required q=4 r=2 dbz=0 dones=1",
                  q, r, z, dn);
      end
   endtask

   task automatic test_exhaustive();
      int bn, dn, da, ov;
      logic [N-1:0] q, r;
      logic z;
      for (int a = 0; a < (1 << N); a++) begin
         for (int b = 0; b < (1 << N); b++) begin
            do_op(N'(a), N'(b), bn, dn, da, ov, q, r, z);
            checks++;
            if (b != 0) begin
               if (int'(q) * b + int'(r) != a || int'(r) >= b || z !== 1'b0) begin
                  failures++;
                  $display("FAIL exh_inv_%0d_%0d: q=%0d r=%0d dbz=%b, required q*b+r=a, r<b, dbz=0",
                           a, b, q, r, z);
               end
            end else begin
               if (q !== '1 || r !== N'(a) || z !== 1'b1) begin
                  failures++;
                  $display("FAIL exh_dz_%0d: q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=1",
                           a, q, r, z, (1 << N) - 1, a);
               end
            end
            checks++;
            if (bn !== ((b != 0) ? N : 0) || dn !== 1 || da !== ((b != 0) ? N + 1 : 1) || ov !== 0) begin
               failures++;
               $display("FAIL exh_timing_%0d_%0d: busy=%0d dones=%0d at=%0d overlap=%0d",
                        a, b, bn, dn, da, ov);
            end
         end
      end
   endtask

   task automatic test_random();
      int bn, dn, da, ov;
      logic [N-1:0] q, r;
      logic z;
      int a, b;
      for (int i = 0; i < 40; i++) begin
         a = $urandom_range((1 << N) - 1, 0);
         b = $urandom_range((1 << N) - 1, 0);
         repeat ($urandom_range(2, 0)) @(negedge clk);
         do_op(N'(a), N'(b), bn, dn, da, ov, q, r, z);
         checks++;
         if (q !== ref_quot(a, b) || r !== ref_rem(a, b) || z !== (b == 0) || dn !== 1) begin
            failures++;
            $display("FAIL rand_%0d_%0d: q=%0d r=%0d dbz=%b dones=%0d, required q=%0d r=%0d dbz=%b dones=1",
                     a, b, q, r, z, dn, ref_quot(a, b), ref_rem(a, b), (b == 0));
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      test_reset();
      test_basic();
      test_extremes();
      test_div_zero();
      test_back_to_back();
      test_reset_mid_run();
      test_exhaustive();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
